acc_host_loader: RTL and testbench
==================================

# acc_host_loader

Host-side command engine that fills the accelerator's instruction and data memories, launches a program, waits for halt, and streams result words back. It sits between a host word stream and the accelerator's write/read/start/halted ports. It is the writer and launcher for the instruction/memory arrays that the accelerator core reads and executes.

## Interface
Parameters:
- NUM_SIZE, 16, data word width
- NUM_INSTRUCTIONS, 16, instruction memory depth (power of two)
- WORDS_IN_MEMORY, 32, data memory depth (power of two)
- TIMEOUT_CYCLES, 1024, run watchdog limit (used only with LOADER_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  host command stream handshake
- in_data  in  32  command or payload word
- out_valid / out_ready  out / in  1 / 1  result stream handshake
- out_data  out  NUM_SIZE  result word
- instr_we  out  1  instruction write strobe
- instr_addr  out  $clog2(NUM_INSTRUCTIONS)  instruction write address
- instr_wdata  out  32  instruction write data
- mem_we  out  1  data write strobe
- mem_addr  out  $clog2(WORDS_IN_MEMORY)  data write address
- mem_wdata  out  NUM_SIZE  data write data
- mem_raddr  out  $clog2(WORDS_IN_MEMORY)  data read address
- mem_rdata  in  NUM_SIZE  data read, combinational from mem_raddr
- acc_start  out  1  one-cycle program launch
- acc_halted  in  1  accelerator halted
- busy  out  1  state != IDLE
- err_cmd  out  1  sticky unknown-command flag
- timeout  out  1  sticky watchdog flag (0 when feature compiled out)

## Operation
- Command word fields: cmd = in_data[31:28], base = in_data[20:16], count = in_data[5:0].
- cmd 1 LOAD_INSTR: next count words are written to instruction addresses base, base+1, and so on.
- cmd 2 LOAD_MEM: next count words are written; in_data[NUM_SIZE-1:0] goes to data addresses base, base+1, and so on.
- cmd 3 RUN: pulse acc_start, then wait for acc_halted.
- cmd 4 READ_MEM: stream count words from data addresses base onward.
- cmd 0 NOP: ignored.
- Any other cmd sets err_cmd. The word is dropped and the engine stays in IDLE.
- Addresses truncate to port width and wrap modulo depth. Example: base 30, count 4 → addresses 30, 31, 0, 1.
- count 0: no payload and no output; return to IDLE the next cycle.
- States: IDLE, LOAD_I, LOAD_M, RUN_START, RUN_WAIT, READ.
  - IDLE → LOAD_I / LOAD_M / RUN_START / READ on acceptance of a command word.
  - LOAD_* → IDLE after the last payload word is accepted.
  - RUN_START → RUN_WAIT after one cycle.
  - RUN_WAIT → IDLE when acc_halted is 1.
  - READ → IDLE when the last word handshakes.

## Timing
- Reset values: all outputs 0 except in_ready = 1. State = IDLE; err_cmd and timeout cleared; counters cleared.
- in_ready = 1 in IDLE, LOAD_I and LOAD_M; 0 otherwise. A word transfers on in_valid & in_ready.
- Write strobes are registered. A payload word accepted at cycle N gives we = 1 at N+1, with addr and data valid. Back-to-back acceptance gives a continuous strobe.
- A command accepted at N+1 after the last payload at N is legal. Zero bubble is required.
- RUN:
  - Command accepted at N → acc_start = 1 at N+1 only.
  - acc_halted is sampled from N+2 onward. Halted already high at N+2 → IDLE at N+3.
- READ:
  - out_valid and out_data are registered.
  - The first word is valid at N+2 after command acceptance at N. mem_raddr is driven during N+1.
  - While out_valid & !out_ready, out_data and out_valid hold.
  - With out_ready held at 1, one word is presented per cycle.
- Reset asserted mid-operation aborts immediately. No further strobes are issued; the engine is in IDLE on release.

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A counter runs in RUN_WAIT.
  - If acc_halted is still 0 after TIMEOUT_CYCLES cycles, set timeout (sticky) and return to IDLE.
- Undefined: RUN_WAIT waits indefinitely; timeout is tied to 0 and no counter is built.

## Structure
- Shared package acc_pkg holds:
  - loader command enum (NOP=0, LOAD_INSTR=1, LOAD_MEM=2, RUN=3, READ_MEM=4)
  - field bit positions
  - state enum
  - NUM_SIZE, NUM_INSTRUCTIONS and WORDS_IN_MEMORY defaults
- Single module; no sub-module is warranted.

## Test plan
- LOAD_INSTR base 0 count 3 with words 0x00041100, 0x00080000, 0x00280000 → three instr_we pulses at addresses 0, 1, 2 with the same data, in consecutive cycles.
- LOAD_MEM base 30 count 4 with data 1, 2, 3, 4 → mem writes (30,1), (31,2), (0,3), (1,4); in_ready stays 1 throughout.
- RUN with acc_halted raised 5 cycles after acc_start:
  - acc_start is exactly one cycle wide.
  - busy = 1 until the cycle after halted, then 0.
  - A second RUN works identically.
- READ_MEM base 8 count 4 against a model memory holding 19, 22, 43, 50, with out_ready toggling 1/0 → out_data sequence 19, 22, 43, 50; values hold while stalled and none is duplicated or dropped.
- cmd 0xF → err_cmd = 1 and stays 1. A subsequent LOAD_MEM count 0 returns to IDLE in one cycle with no mem_we.
- Reset during LOAD_MEM after 2 of 4 payload words → no further mem_we, all outputs at reset values. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, a RUN with acc_halted held at 0 sets timeout after 16 cycles.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator host loader: command codes, command-word
// field positions, loader FSM states and default memory geometry.
package acc_pkg;

    localparam int NUM_SIZE_DEF         = 16;
    localparam int NUM_INSTRUCTIONS_DEF = 16;
    localparam int WORDS_IN_MEMORY_DEF  = 32;

    localparam int CMD_MSB   = 31;
    localparam int CMD_LSB   = 28;
    localparam int BASE_MSB  = 20;
    localparam int BASE_LSB  = 16;
    localparam int COUNT_MSB = 5;
    localparam int COUNT_LSB = 0;
    localparam int CMD_W     = CMD_MSB - CMD_LSB + 1;
    localparam int BASE_W    = BASE_MSB - BASE_LSB + 1;
    localparam int COUNT_W   = COUNT_MSB - COUNT_LSB + 1;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP        = 4'd0,
        CMD_LOAD_INSTR = 4'd1,
        CMD_LOAD_MEM   = 4'd2,
        CMD_RUN        = 4'd3,
        CMD_READ_MEM   = 4'd4
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_M,
        RUN_START,
        RUN_WAIT,
        READ
    } state_e;

endpackage

// File: rtl/acc_host_loader_if.sv
// Host stream, result stream and accelerator memory/control ports of the loader.
// master = loader side, slave = host plus accelerator side.
interface acc_host_loader_if
    import acc_pkg::*;
#(
    parameter int NUM_SIZE         = NUM_SIZE_DEF,
    parameter int NUM_INSTRUCTIONS = NUM_INSTRUCTIONS_DEF,
    parameter int WORDS_IN_MEMORY  = WORDS_IN_MEMORY_DEF
);
    localparam int IA_W = $clog2(NUM_INSTRUCTIONS);
    localparam int MA_W = $clog2(WORDS_IN_MEMORY);

    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_SIZE-1:0] out_data;
    logic                instr_we;
    logic [IA_W-1:0]     instr_addr;
    logic [31:0]         instr_wdata;
    logic                mem_we;
    logic [MA_W-1:0]     mem_addr;
    logic [NUM_SIZE-1:0] mem_wdata;
    logic [MA_W-1:0]     mem_raddr;
    logic [NUM_SIZE-1:0] mem_rdata;
    logic                acc_start;
    logic                acc_halted;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata, acc_halted,
        output in_ready, out_valid, out_data, instr_we, instr_addr, instr_wdata,
        output mem_we, mem_addr, mem_wdata, mem_raddr, acc_start
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata, acc_halted,
        input  in_ready, out_valid, out_data, instr_we, instr_addr, instr_wdata,
        input  mem_we, mem_addr, mem_wdata, mem_raddr, acc_start
    );

endinterface

// File: rtl/acc_host_loader.sv
// Host command engine: loads instruction/data memories, launches a run, streams results.
// Optional run watchdog compiled in with LOADER_TIMEOUT_EN.
module acc_host_loader
    import acc_pkg::*;
#(
    parameter int NUM_SIZE         = NUM_SIZE_DEF,
    parameter int NUM_INSTRUCTIONS = NUM_INSTRUCTIONS_DEF,
    parameter int WORDS_IN_MEMORY  = WORDS_IN_MEMORY_DEF,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    acc_host_loader_if.master bus,
    output logic              busy,
    output logic              err_cmd,
    output logic              timeout
);
    localparam int IA_W  = $clog2(NUM_INSTRUCTIONS);
    localparam int MA_W  = $clog2(WORDS_IN_MEMORY);
    localparam int PTR_W = (IA_W > MA_W) ? IA_W : MA_W;

    state_e              state_reg;
    logic [COUNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]    ptr_reg;
    logic                instr_we_reg;
    logic [IA_W-1:0]     instr_addr_reg;
    logic [31:0]         instr_wdata_reg;
    logic                mem_we_reg;
    logic [MA_W-1:0]     mem_addr_reg;
    logic [NUM_SIZE-1:0] mem_wdata_reg;
    logic                acc_start_reg;
    logic                out_valid_reg;
    logic [NUM_SIZE-1:0] out_data_reg;
    logic                err_cmd_reg;

    logic               in_ready_int;
    logic               in_fire;
    logic               out_fire;
    logic               fetch;
    logic [CMD_W-1:0]   cmd_field;
    logic [BASE_W-1:0]  base_field;
    logic [COUNT_W-1:0] count_field;

    assign cmd_field    = bus.in_data[CMD_MSB:CMD_LSB];
    assign base_field   = bus.in_data[BASE_MSB:BASE_LSB];
    assign count_field  = bus.in_data[COUNT_MSB:COUNT_LSB];
    assign in_ready_int = (state_reg == IDLE) || (state_reg == LOAD_I) || (state_reg == LOAD_M);
    assign in_fire      = bus.in_valid && in_ready_int;
    assign out_fire     = out_valid_reg && bus.out_ready;
    // A new read is issued whenever the output register is empty or draining this cycle.
    assign fetch        = (state_reg == READ) && (count_reg != '0) && (!out_valid_reg || bus.out_ready);

`ifdef LOADER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;
    logic             timeout_reg;
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            ptr_reg         <= '0;
            instr_we_reg    <= 1'b0;
            instr_addr_reg  <= '0;
            instr_wdata_reg <= '0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            acc_start_reg   <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            err_cmd_reg     <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            timer_reg       <= '0;
            timeout_reg     <= 1'b0;
`endif
        end else begin
            instr_we_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            acc_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_fire) begin
                        case (cmd_field)
                            CMD_NOP: ;
                            CMD_LOAD_INSTR, CMD_LOAD_MEM, CMD_READ_MEM: begin
                                ptr_reg   <= PTR_W'(base_field);
                                count_reg <= count_field;
                                // A zero count never leaves IDLE, so no payload is expected.
                                if (count_field != '0) begin
                                    if (cmd_field == CMD_LOAD_INSTR)    state_reg <= LOAD_I;
                                    else if (cmd_field == CMD_LOAD_MEM) state_reg <= LOAD_M;
                                    else                                state_reg <= READ;
                                end
                            end
                            CMD_RUN: begin
                                acc_start_reg <= 1'b1;
                                state_reg     <= RUN_START;
                            end
                            default: err_cmd_reg <= 1'b1;
                        endcase
                    end
                end
                LOAD_I: begin
                    if (in_fire) begin
                        instr_we_reg    <= 1'b1;
                        instr_addr_reg  <= ptr_reg[IA_W-1:0];
                        instr_wdata_reg <= bus.in_data;
                        ptr_reg         <= ptr_reg + 1'b1;
                        count_reg       <= count_reg - 1'b1;
                        if (count_reg == COUNT_W'(1)) state_reg <= IDLE;
                    end
                end
                LOAD_M: begin
                    if (in_fire) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= ptr_reg[MA_W-1:0];
                        mem_wdata_reg <= bus.in_data[NUM_SIZE-1:0];
                        ptr_reg       <= ptr_reg + 1'b1;
                        count_reg     <= count_reg - 1'b1;
                        if (count_reg == COUNT_W'(1)) state_reg <= IDLE;
                    end
                end
                RUN_START: begin
                    state_reg <= RUN_WAIT;
`ifdef LOADER_TIMEOUT_EN
                    timer_reg <= '0;
`endif
                end
                RUN_WAIT: begin
                    if (bus.acc_halted) begin
                        state_reg <= IDLE;
`ifdef LOADER_TIMEOUT_EN
                    end else if (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
`endif
                    end
                end
                READ: begin
                    if (fetch) begin
                        out_data_reg  <= bus.mem_rdata;
                        out_valid_reg <= 1'b1;
                        ptr_reg       <= ptr_reg + 1'b1;
                        count_reg     <= count_reg - 1'b1;
                    end else if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        if (count_reg == '0) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.instr_we    = instr_we_reg;
    assign bus.instr_addr  = instr_addr_reg;
    assign bus.instr_wdata = instr_wdata_reg;
    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_wdata   = mem_wdata_reg;
    assign bus.mem_raddr   = ptr_reg[MA_W-1:0];
    assign bus.acc_start   = acc_start_reg;
    assign busy            = (state_reg != IDLE);
    assign err_cmd         = err_cmd_reg;

endmodule

// File: tb/tb_acc_host_loader.sv
// Scoreboard bench for acc_host_loader: stimulus pushes expected writes/results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_acc_host_loader;
    import acc_pkg::*;

    localparam int NS = 16;
    localparam int NI = 16;
    localparam int NW = 32;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, err_cmd, timeout;
    logic out_ready_v = 1'b1;
    logic rdy_toggle  = 1'b0;
    logic [NS-1:0] model_mem [NW];

    int checks = 0;
    int errors = 0;

    wr_t         exp_instr [$];
    wr_t         exp_mem   [$];
    logic [15:0] exp_out   [$];

    always #5 clk = ~clk;

    acc_host_loader_if #(.NUM_SIZE(NS), .NUM_INSTRUCTIONS(NI), .WORDS_IN_MEMORY(NW)) bus ();

    acc_host_loader #(
        .NUM_SIZE(NS), .NUM_INSTRUCTIONS(NI), .WORDS_IN_MEMORY(NW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_cmd(err_cmd), .timeout(timeout)
    );

    assign bus.mem_rdata = model_mem[bus.mem_raddr];
    assign bus.out_ready = out_ready_v;

    always @(posedge clk) begin
        #1;
        out_ready_v = rdy_toggle ? ~out_ready_v : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    // Monitor
    int   cyc = 0;
    int   start_pulses = 0;
    int   iwe_seen = 0;
    int   iwe_gaps = 0;
    int   last_iwe = 0;
    logic stalled = 1'b0;
    logic [15:0] stall_data = '0;
    wr_t  e;
    logic [15:0] eo;

    always @(negedge clk) begin
        cyc++;
        if (bus.acc_start) start_pulses++;
        if (bus.instr_we) begin
            if (exp_instr.size() == 0) begin
                checks++; errors++;
                $display("FAIL instr_unexpected actual addr=%0d data=%0h required no write", bus.instr_addr, bus.instr_wdata);
            end else begin
                e = exp_instr.pop_front();
                chk("instr_addr", 32'(bus.instr_addr), 32'(e.addr[3:0]));
                chk("instr_data", bus.instr_wdata, e.data);
                $display("instr write addr=%0d data=%08h", bus.instr_addr, bus.instr_wdata);
            end
            if (iwe_seen > 0 && cyc != last_iwe + 1) iwe_gaps++;
            last_iwe = cyc;
            iwe_seen++;
        end
        if (bus.mem_we) begin
            if (exp_mem.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_unexpected actual addr=%0d data=%0h required no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_mem.pop_front();
                chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("mem_data", 32'(bus.mem_wdata), e.data);
                $display("mem write addr=%0d data=%04h", bus.mem_addr, bus.mem_wdata);
            end
        end
        if (bus.out_valid) begin
            if (stalled) chk("out_hold", 32'(bus.out_data), 32'(stall_data));
            if (bus.out_ready) begin
                stalled = 1'b0;
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected actual=%0d required no word", bus.out_data);
                end else begin
                    eo = exp_out.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(eo));
                    $display("out word data=%0d", bus.out_data);
                end
            end else begin
                stalled    = 1'b1;
                stall_data = bus.out_data;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds in_valid after acceptance so consecutive calls stream with no bubble.
    task automatic send(input logic [31:0] w);
        bit ok;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout actual in_ready=0 required 1 word=%08h", w);
        end
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            step(1);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s actual busy=1 required 0 within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.acc_halted = 1'b0;
        for (int i = 0; i < NW; i++) model_mem[i] = 16'(i * 3);
        model_mem[8]  = 16'd19;
        model_mem[9]  = 16'd22;
        model_mem[10] = 16'd43;
        model_mem[11] = 16'd50;

        // Reset state
        step(3);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_instr_we", 32'(bus.instr_we), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_acc_start", 32'(bus.acc_start), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err_cmd", 32'(err_cmd), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b1;
        step(1);

        // LOAD_INSTR followed with no bubble by LOAD_MEM wrapping 30,31,0,1
        exp_instr.push_back(mk(5'd0, 32'h00041100));
        exp_instr.push_back(mk(5'd1, 32'h00080000));
        exp_instr.push_back(mk(5'd2, 32'h00280000));
        send(32'h10000003);
        send(32'h00041100);
        send(32'h00080000);
        send(32'h00280000);
        exp_mem.push_back(mk(5'd30, 32'd1));
        exp_mem.push_back(mk(5'd31, 32'd2));
        exp_mem.push_back(mk(5'd0, 32'd3));
        exp_mem.push_back(mk(5'd1, 32'd4));
        send(32'h201E0004);
        for (int i = 1; i <= 4; i++) begin
            send(32'(i));
            chk("load_mem_in_ready", 32'(bus.in_ready), 32'd1);
        end
        idle_in();
        step(2);
        chk("instr_we_count", 32'(iwe_seen), 32'd3);
        chk("instr_we_gaps", 32'(iwe_gaps), 32'd0);
        chk("instr_queue_left", 32'(exp_instr.size()), 32'd0);
        chk("mem_queue_left", 32'(exp_mem.size()), 32'd0);
        chk("load_busy_done", 32'(busy), 32'd0);

        // Two RUNs, halted raised 5 cycles after acc_start
        for (int r = 0; r < 2; r++) begin
            p0 = start_pulses;
            send(32'h30000000);
            idle_in();
            chk("run_start_hi", 32'(bus.acc_start), 32'd1);
            step(1);
            chk("run_start_lo", 32'(bus.acc_start), 32'd0);
            step(3);
            chk("run_busy_wait", 32'(busy), 32'd1);
            step(1);
            bus.acc_halted = 1'b1;
            chk("run_busy_halt", 32'(busy), 32'd1);
            step(1);
            chk("run_busy_after", 32'(busy), 32'd0);
            bus.acc_halted = 1'b0;
            chk("run_start_pulses", 32'(start_pulses - p0), 32'd1);
            $display("run %0d done", r);
        end

        // READ_MEM base 8 count 4 with out_ready toggling
        exp_out.push_back(16'd19);
        exp_out.push_back(16'd22);
        exp_out.push_back(16'd43);
        exp_out.push_back(16'd50);
        rdy_toggle = 1'b1;
        send(32'h40080004);
        idle_in();
        wait_idle("read_done", 200);
        rdy_toggle = 1'b0;
        step(3);
        chk("out_queue_left", 32'(exp_out.size()), 32'd0);
        chk("read_out_valid_low", 32'(bus.out_valid), 32'd0);

        // Unknown command, then LOAD_MEM count 0
        send(32'hF0000000);
        idle_in();
        chk("err_cmd_set", 32'(err_cmd), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        send(32'h20000000);
        idle_in();
        chk("cnt0_busy", 32'(busy), 32'd0);
        chk("cnt0_in_ready", 32'(bus.in_ready), 32'd1);
        step(3);
        chk("err_cmd_sticky", 32'(err_cmd), 32'd1);

        // Reset during LOAD_MEM after 2 of 4 payload words
        exp_mem.push_back(mk(5'd4, 32'h0000AAAA));
        exp_mem.push_back(mk(5'd5, 32'h0000BBBB));
        send(32'h20040004);
        send(32'h0000AAAA);
        send(32'h0000BBBB);
        bus.in_data = 32'h0000CCCC;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err_cmd", 32'(err_cmd), 32'd0);
        idle_in();
        step(3);
        rst = 1'b1;
        step(3);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_mem_queue", 32'(exp_mem.size()), 32'd0);

`ifdef LOADER_TIMEOUT_EN
        // RUN with acc_halted held low: watchdog after 16 wait cycles
        send(32'h30000000);
        idle_in();
        step(16);
        chk("to_not_yet", 32'(timeout), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        step(1);
        chk("to_set", 32'(timeout), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        step(2);
        chk("to_sticky", 32'(timeout), 32'd1);
`else
        chk("timeout_tied", 32'(timeout), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
